// File: rtl/button_conditioner.sv
// button_conditioner: N-channel polarity normalise, 2-FF sync, debounce, press/long/typematic events.
// Ports: clk, rst (sync, high), btn[N] raw pins -> held, pressed, released, long_press, auto_repeat [N].
module button_conditioner #(
  parameter int N          = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int DEBOUNCE   = 1000000,
  parameter int LONG       = 25000000,
  parameter int REPEAT     = 5000000,
  parameter int REPEAT_EN  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn,
  output logic [N-1:0] held,
  output logic [N-1:0] pressed,
  output logic [N-1:0] released,
  output logic [N-1:0] long_press,
  output logic [N-1:0] auto_repeat
);

  localparam int DW   = $clog2(DEBOUNCE);
  localparam int HMAX = (LONG > REPEAT) ? LONG : REPEAT;
  localparam int HW   = $clog2(HMAX);

  localparam logic [DW-1:0] D_END = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] L_END = HW'(LONG - 1);
  localparam logic [HW-1:0] R_END = HW'(REPEAT - 1);

  logic [N-1:0] a;
  logic [N-1:0] s1;
  logic [N-1:0] s2;

  assign a = (ACTIVE_LOW != 0) ? ~btn : btn;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= a;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic          lp_done;
    logic          h;
    logic          p;
    logic          r;
    logic          lp;
    logic          rp;
    logic          settle;
    logic          rise;
    logic          fall;

    always_comb begin
      settle = (s2[i] != h) && (dcnt == D_END);
      rise   = settle && s2[i];
      fall   = settle && !s2[i];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dcnt    <= '0;
        hcnt    <= '0;
        lp_done <= 1'b0;
        h       <= 1'b0;
        p       <= 1'b0;
        r       <= 1'b0;
        lp      <= 1'b0;
        rp      <= 1'b0;
      end else begin
        p  <= rise;
        r  <= fall;
        lp <= 1'b0;
        rp <= rise;

        if (s2[i] == h) begin
          dcnt <= '0;
        end else if (dcnt == D_END) begin
          h    <= s2[i];
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end

        // A fall in this cycle pre-empts any long/repeat due now,
        // so released never overlaps them.
        if (!h || fall) begin
          hcnt    <= '0;
          lp_done <= 1'b0;
        end else if (!lp_done) begin
          if (hcnt == L_END) begin
            lp      <= 1'b1;
            rp      <= (REPEAT_EN != 0);
            lp_done <= 1'b1;
            hcnt    <= '0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end else if (REPEAT_EN != 0) begin
          // Reload each period: no wrap for arbitrarily long holds.
          if (hcnt == R_END) begin
            rp   <= 1'b1;
            hcnt <= '0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
      end
    end

    assign held[i]        = h;
    assign pressed[i]     = p;
    assign released[i]    = r;
    assign long_press[i]  = lp;
    assign auto_repeat[i] = rp;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed pin stimulus, expected pulses queued per cycle.
// Two DUTs share stimulus: u0 with auto-repeat, u1 without.
module tb_button_conditioner;

  localparam int K_P   = 0;
  localparam int K_R   = 1;
  localparam int K_L   = 2;
  localparam int K_RP  = 3;
  localparam int K_RP1 = 4;
  localparam int K_RST = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn = 2'b11;

  logic [1:0] held0, pr0, rl0, lp0, rp0;
  logic [1:0] held1, pr1, rl1, lp1, rp1;

  button_conditioner #(
    .N(2), .ACTIVE_LOW(1), .DEBOUNCE(4),
    .LONG(10), .REPEAT(3), .REPEAT_EN(1)
  ) u0 (
    .clk(clk), .rst(rst), .btn(btn),
    .held(held0), .pressed(pr0), .released(rl0),
    .long_press(lp0), .auto_repeat(rp0)
  );

  button_conditioner #(
    .N(2), .ACTIVE_LOW(1), .DEBOUNCE(4),
    .LONG(10), .REPEAT(3), .REPEAT_EN(0)
  ) u1 (
    .clk(clk), .rst(rst), .btn(btn),
    .held(held1), .pressed(pr1), .released(rl1),
    .long_press(lp1), .auto_repeat(rp1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int k;
    int ch;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  logic [1:0] hexp = 2'b00;
  logic [1:0] ep, er, el, erp, erp1;

  task automatic ex(input int c, input int k, input int ch);
    ev_t e;
    e.c  = c;
    e.k  = k;
    e.ch = ch;
    q.push_back(e);
  endtask

  task automatic press_ev(input int t, input int ch);
    ex(t, K_P, ch);
    ex(t, K_RP, ch);
    ex(t, K_RP1, ch);
  endtask

  task automatic cmp(input string nm, input logic [1:0] act,
                     input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b",
               nm, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      ep   = '0;
      er   = '0;
      el   = '0;
      erp  = '0;
      erp1 = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].c == cyc) begin
          case (q[i].k)
            K_P: begin
              ep[q[i].ch]   = 1'b1;
              hexp[q[i].ch] = 1'b1;
            end
            K_R: begin
              er[q[i].ch]   = 1'b1;
              hexp[q[i].ch] = 1'b0;
            end
            K_L:   el[q[i].ch]   = 1'b1;
            K_RP:  erp[q[i].ch]  = 1'b1;
            K_RP1: erp1[q[i].ch] = 1'b1;
            default: hexp = '0;
          endcase
          q.delete(i);
        end
      end
      cmp("held", held0, hexp);
      cmp("pressed", pr0, ep);
      cmp("released", rl0, er);
      cmp("long_press", lp0, el);
      cmp("repeat", rp0, erp);
      cmp("held_norep", held1, hexp);
      cmp("pressed_norep", pr1, ep);
      cmp("released_norep", rl1, er);
      cmp("long_norep", lp1, el);
      cmp("repeat_norep", rp1, erp1);
    end
  end

  task automatic to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    to(1);
    mon_en = 1'b1;
    to(3);
    rst = 1'b0;

    // clean press, long hold with typematic train, release
    to(10);
    btn[0] = 1'b0;
    press_ev(16, 0);
    ex(26, K_L, 0);
    for (int c = 26; c <= 50; c += 3) ex(c, K_RP, 0);
    to(46);
    btn[0] = 1'b1;
    ex(52, K_R, 0);

    // 3-cycle glitch rejected, 5-cycle pulse accepted
    to(60);
    btn[0] = 1'b0;
    to(63);
    btn[0] = 1'b1;
    to(80);
    btn[0] = 1'b0;
    press_ev(86, 0);
    to(85);
    btn[0] = 1'b1;
    ex(91, K_R, 0);

    // short hold: held falls at t+8
    to(100);
    btn[0] = 1'b0;
    press_ev(106, 0);
    to(108);
    btn[0] = 1'b1;
    ex(114, K_R, 0);

    // held falls exactly at t+LONG: long suppressed
    to(130);
    btn[0] = 1'b0;
    press_ev(136, 0);
    to(140);
    btn[0] = 1'b1;
    ex(146, K_R, 0);

    // fresh schedule; fall lands on a due repeat
    to(160);
    btn[0] = 1'b0;
    press_ev(166, 0);
    ex(176, K_L, 0);
    ex(176, K_RP, 0);
    ex(179, K_RP, 0);
    to(176);
    btn[0] = 1'b1;
    ex(182, K_R, 0);

    // two channels offset by 2 cycles
    to(200);
    btn[0] = 1'b0;
    press_ev(206, 0);
    ex(216, K_L, 0);
    ex(216, K_RP, 0);
    to(202);
    btn[1] = 1'b0;
    press_ev(208, 1);
    ex(218, K_L, 1);
    ex(218, K_RP, 1);
    ex(221, K_RP, 1);
    ex(224, K_RP, 1);
    to(212);
    btn[0] = 1'b1;
    ex(218, K_R, 0);
    to(220);
    btn[1] = 1'b1;
    ex(226, K_R, 1);

    // reset mid-debounce, button kept down
    to(240);
    btn[0] = 1'b0;
    to(243);
    rst = 1'b1;
    ex(244, K_RST, 0);
    to(244);
    rst = 1'b0;
    press_ev(250, 0);

    // reset at t+5 of a hold
    to(254);
    rst = 1'b1;
    ex(255, K_RST, 0);
    to(255);
    rst = 1'b0;
    press_ev(261, 0);
    ex(271, K_L, 0);
    ex(271, K_RP, 0);
    ex(274, K_RP, 0);
    ex(277, K_RP, 0);
    to(272);
    btn[0] = 1'b1;
    ex(278, K_R, 0);

    to(300);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events actual=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
